// File: rtl/osc_sample_capture_pkg.sv
// Shared definitions for the oscilloscope sample-capture block.
// Contents: Avalon register word addresses, status and control bit
// positions, and the capture FSM state enum.
package osc_capture_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_LEVEL   = 3'd2;
  localparam logic [2:0] ADDR_LENGTH  = 3'd3;
  localparam logic [2:0] ADDR_DATA    = 3'd4;
  localparam logic [2:0] ADDR_COUNT   = 3'd5;
  localparam logic [2:0] ADDR_DECIM   = 3'd6;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_TRIG      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_CNT_VALID = 4;

  localparam int unsigned CT_START  = 0;
  localparam int unsigned CT_STOP   = 1;
  localparam int unsigned CT_SLOPE  = 2;
  localparam int unsigned CT_AUTO   = 3;
  localparam int unsigned CT_IRQ_EN = 4;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_e;

endpackage

// File: rtl/osc_sample_capture_if.sv
// 16-bit Avalon-MM slave bus of the sample-capture block.
// master: drives address/chipselect/write_n/read_n/writedata, receives readdata.
// slave:  the opposite directions.
interface osc_sample_capture_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata,
                  input readdata);
  modport slave  (input address, chipselect, write_n, read_n, writedata,
                  output readdata);
endinterface

// File: rtl/osc_trigger_detect.sv
// Sample-tick edge detection and level/slope/auto trigger compare.
// Ports: clk, reset_n; sample_tick/adc_data raw inputs; level, slope,
// auto_mode configuration; arm (start pulse), armed (FSM in ARMED),
// tick_en (tick accepted by the top); tick = rising edge of sample_tick,
// trig_hit = trigger condition on the current accepted tick.
module osc_trigger_detect #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  input  logic              auto_mode,
  input  logic              arm,
  input  logic              armed,
  input  logic              tick_en,
  output logic              tick,
  output logic              trig_hit
);

  logic              tick_sync;
  logic              first;
  logic [DATA_W-1:0] prev;
  logic              cmp_c;

  // first marks that no tick has been seen since arming; that tick only loads prev
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_sync <= 1'b0;
      first     <= 1'b0;
      prev      <= '0;
    end else begin
      tick_sync <= sample_tick;
      if (arm) first <= 1'b1;
      else if (armed && tick_en) first <= 1'b0;
      if (armed && tick_en) prev <= adc_data;
    end
  end

  assign tick = sample_tick & ~tick_sync;

  always_comb begin
    cmp_c = 1'b0;
    if (slope) cmp_c = (prev > level) && (adc_data <= level);
    else       cmp_c = (prev < level) && (adc_data >= level);
  end

  assign trig_hit = armed & tick_en & (first ? auto_mode : cmp_c);

endmodule

// File: rtl/osc_sample_capture.sv
// Oscilloscope acquisition stage: triggers on level/slope (or auto), stores a
// post-trigger record in an inferred dual-port RAM, and exposes it over a
// 16-bit Avalon-MM slave. Optional decimation register is built when
// OSC_DECIM_EN is defined.
// Ports: clk, reset_n; sample_tick (timer irq), adc_data; bus (Avalon slave
// modport); irq = done & irq_en.
module osc_sample_capture
  import osc_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_data,
  osc_sample_capture_if.slave bus,
  output logic              irq
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);

  cap_state_e state, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  rd_ptr, count, length;
  logic [DATA_W-1:0] trig_level;
  logic              triggered, done, overflow;
  logic              slope, auto_mode, irq_en;

  logic wr_c, rd_c, ctrl_wr_c, status_wr_c, start_c, stop_c;
  logic tick_raw, tick_acc_c, trig_hit, decim_ok_c;
  logic busy_c, armed_c, cap_wr_c, done_set_c, ovf_set_c;
  logic [15:0] decim_rd;

  assign wr_c        = bus.chipselect & ~bus.write_n;
  assign rd_c        = bus.chipselect & ~bus.read_n;
  assign ctrl_wr_c   = wr_c && (bus.address == ADDR_CONTROL);
  assign status_wr_c = wr_c && (bus.address == ADDR_STATUS);
  // stop overrides start when both bits are written together
  assign stop_c      = ctrl_wr_c & bus.writedata[CT_STOP];
  assign start_c     = ctrl_wr_c & bus.writedata[CT_START] & ~bus.writedata[CT_STOP];

`ifdef OSC_DECIM_EN
  logic [15:0] decim, decim_cnt;

  // accept one tick, then skip decim ticks; counter wraps once it reaches decim
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      decim     <= '0;
      decim_cnt <= '0;
    end else begin
      if (wr_c && (bus.address == ADDR_DECIM)) decim <= bus.writedata;
      if (start_c) decim_cnt <= '0;
      else if (tick_raw) decim_cnt <= (decim_cnt >= decim) ? 16'd0 : decim_cnt + 16'd1;
    end
  end

  assign decim_ok_c = (decim_cnt == 16'd0);
  assign decim_rd   = decim;
`else
  assign decim_ok_c = 1'b1;
  assign decim_rd   = 16'd0;
`endif

  // a tick coinciding with start is dropped
  assign tick_acc_c = tick_raw & decim_ok_c & ~start_c;
  assign armed_c    = (state == ARMED);

  osc_trigger_detect #(.DATA_W(DATA_W)) u_trig (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .adc_data   (adc_data),
    .level      (trig_level),
    .slope      (slope),
    .auto_mode  (auto_mode),
    .arm        (start_c),
    .armed      (armed_c),
    .tick_en    (tick_acc_c),
    .tick       (tick_raw),
    .trig_hit   (trig_hit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = IDLE;
      ARMED:   if (trig_hit) state_d = CAPTURE;
      CAPTURE: if (count == length) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop_c)       state_d = IDLE;
    else if (start_c) state_d = ARMED;
  end

  // FSM outputs
  always_comb begin
    busy_c     = 1'b0;
    cap_wr_c   = 1'b0;
    done_set_c = 1'b0;
    ovf_set_c  = 1'b0;
    case (state)
      ARMED: begin
        busy_c   = 1'b1;
        cap_wr_c = trig_hit;
      end
      CAPTURE: begin
        busy_c   = 1'b1;
        cap_wr_c = tick_acc_c && (count != length);
      end
      DONE: begin
        done_set_c = 1'b1;
        ovf_set_c  = tick_acc_c;
      end
      default: ;
    endcase
    if (stop_c) cap_wr_c = 1'b0;
  end

  // sample buffer write port
  always_ff @(posedge clk) begin
    if (cap_wr_c) mem[wr_ptr] <= adc_data;
  end

  // pointers, flags and configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      slope      <= 1'b0;
      auto_mode  <= 1'b0;
      irq_en     <= 1'b0;
      trig_level <= '0;
      length     <= DEPTH_V;
    end else begin
      if (start_c) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        triggered <= 1'b0;
        done      <= 1'b0;
      end else begin
        if (cap_wr_c) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          count  <= count + CNT_W'(1);
          if (armed_c) triggered <= 1'b1;
        end
        if (done_set_c)       done <= 1'b1;
        else if (status_wr_c) done <= 1'b0;
        if (rd_c && (bus.address == ADDR_DATA) && (rd_ptr != count))
          rd_ptr <= rd_ptr + CNT_W'(1);
      end
      if (ovf_set_c)        overflow <= 1'b1;
      else if (status_wr_c) overflow <= 1'b0;
      if (ctrl_wr_c) begin
        slope     <= bus.writedata[CT_SLOPE];
        auto_mode <= bus.writedata[CT_AUTO];
        irq_en    <= bus.writedata[CT_IRQ_EN];
      end
      if (wr_c && (bus.address == ADDR_LEVEL)) trig_level <= bus.writedata[DATA_W-1:0];
      if (wr_c && (bus.address == ADDR_LENGTH)) begin
        if (bus.writedata == 16'd0)             length <= CNT_W'(1);
        else if (bus.writedata > 16'(DEPTH))    length <= DEPTH_V;
        else                                    length <= CNT_W'(bus.writedata);
      end
    end
  end

  // registered read data mux; buffer read at rd_ptr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 16'd0;
    end else if (rd_c) begin
      case (bus.address)
        ADDR_STATUS:  bus.readdata <= {11'd0, (count != '0), overflow, triggered, done, busy_c};
        ADDR_CONTROL: bus.readdata <= {11'd0, irq_en, auto_mode, slope, 2'b00};
        ADDR_LEVEL:   bus.readdata <= 16'(trig_level);
        ADDR_LENGTH:  bus.readdata <= 16'(length);
        ADDR_DATA:    bus.readdata <= (rd_ptr == count) ? 16'd0 : 16'(mem[rd_ptr[ADDR_W-1:0]]);
        ADDR_COUNT:   bus.readdata <= 16'(count);
        ADDR_DECIM:   bus.readdata <= decim_rd;
        default:      bus.readdata <= 16'd0;
      endcase
    end
  end

  assign irq = done & irq_en;

endmodule

// File: tb/tb_osc_sample_capture.sv
// Directed self-checking bench for osc_sample_capture.
module tb_osc_sample_capture;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic [7:0] adc_data = 8'd0;
  logic       irq;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] rd;

  osc_sample_capture_if bus();

  osc_sample_capture dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .adc_data   (adc_data),
    .bus        (bus),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic av_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic av_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    d = bus.readdata;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    av_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic do_tick(input logic [7:0] d);
    @(negedge clk);
    adc_data = d; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.read_n = 1'b1; bus.writedata = 16'd0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset values
    check("reset_readdata", bus.readdata, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    rd_check("reset_status", 3'd0, 16'h0000);
    rd_check("reset_control", 3'd1, 16'h0000);
    rd_check("reset_level", 3'd2, 16'h0000);
    rd_check("reset_length", 3'd3, 16'h0400);
    rd_check("reset_data", 3'd4, 16'h0000);
    rd_check("reset_count", 3'd5, 16'h0000);

    // 2: rising trigger at 0x80, 4-sample record, irq enabled
    av_write(3'd2, 16'h0080);
    av_write(3'd3, 16'h0004);
    av_write(3'd1, 16'h0011);
    do_tick(8'h70); do_tick(8'h7C); do_tick(8'h84);
    do_tick(8'h90); do_tick(8'h9C); do_tick(8'hA8);
    check("rise_irq", {15'd0, irq}, 16'h0001);
    rd_check("rise_status", 3'd0, 16'h0016);
    rd_check("rise_control", 3'd1, 16'h0010);
    rd_check("rise_count", 3'd5, 16'h0004);
    rd_check("rise_data0", 3'd4, 16'h0084);
    rd_check("rise_data1", 3'd4, 16'h0090);
    rd_check("rise_data2", 3'd4, 16'h009C);
    rd_check("rise_data3", 3'd4, 16'h00A8);
    rd_check("rise_data_end", 3'd4, 16'h0000);
    av_write(3'd0, 16'h0000);
    check("irq_cleared", {15'd0, irq}, 16'h0000);
    rd_check("status_cleared", 3'd0, 16'h0014);

    // 3: falling trigger at 0x40; then rising with flat input never triggers
    av_write(3'd2, 16'h0040);
    av_write(3'd1, 16'h0005);
    do_tick(8'h50); do_tick(8'h40);
    rd_check("fall_status", 3'd0, 16'h0015);
    rd_check("fall_count", 3'd5, 16'h0001);
    rd_check("fall_data", 3'd4, 16'h0040);
    av_write(3'd2, 16'h0080);
    av_write(3'd1, 16'h0001);
    do_tick(8'h80); do_tick(8'h80); do_tick(8'h80);
    rd_check("flat_status", 3'd0, 16'h0001);
    av_write(3'd1, 16'h0002);
    rd_check("stop_status", 3'd0, 16'h0000);
    rd_check("stop_count", 3'd5, 16'h0000);

    // 4: auto trigger, length clamping
    av_write(3'd3, 16'h0000);
    rd_check("len_zero", 3'd3, 16'h0001);
    av_write(3'd1, 16'h0009);
    do_tick(8'h33);
    rd_check("auto_status", 3'd0, 16'h0016);
    rd_check("auto_count", 3'd5, 16'h0001);
    rd_check("auto_data", 3'd4, 16'h0033);
    check("auto_irq_masked", {15'd0, irq}, 16'h0000);
    av_write(3'd3, 16'd2000);
    rd_check("len_clamp", 3'd3, 16'h0400);

    // 5: start+stop together, restart mid-capture, held tick level
    av_write(3'd0, 16'h0000);
    av_write(3'd1, 16'h000B);
    rd_check("startstop_status", 3'd0, 16'h0014);
    av_write(3'd3, 16'h0004);
    av_write(3'd1, 16'h0009);
    do_tick(8'h11); do_tick(8'h22);
    rd_check("mid_count", 3'd5, 16'h0002);
    rd_check("mid_status", 3'd0, 16'h0015);
    av_write(3'd1, 16'h0009);
    rd_check("restart_count", 3'd5, 16'h0000);
    rd_check("restart_status", 3'd0, 16'h0001);
    @(negedge clk);
    adc_data = 8'h5A; sample_tick = 1'b1;
    repeat (10) @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rd_check("held_count", 3'd5, 16'h0001);
    rd_check("held_data", 3'd4, 16'h005A);

    // 6: decimation register
`ifdef OSC_DECIM_EN
    av_write(3'd6, 16'h0002);
    rd_check("decim_rd", 3'd6, 16'h0002);
    av_write(3'd3, 16'h0003);
    av_write(3'd1, 16'h0009);
    for (int i = 1; i <= 9; i++) do_tick(8'(i));
    rd_check("decim_count", 3'd5, 16'h0003);
    rd_check("decim_d0", 3'd4, 16'h0001);
    rd_check("decim_d1", 3'd4, 16'h0004);
    rd_check("decim_d2", 3'd4, 16'h0007);
`else
    av_write(3'd6, 16'h0002);
    rd_check("decim_absent", 3'd6, 16'h0000);
`endif

    av_read(3'd7, rd);
    check("addr7_zero", rd, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
